// File: rtl/control.sv
// Multicycle controller for a 16-bit load/store datapath: a Moore FSM whose
// outputs are a pure decode of the current state, forced low while rst_n=0.
module control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       alumux_sel,
  output logic       regfilemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [1:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable
);

  localparam int unsigned OP_W    = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned BE_W    = 2;

  localparam logic [OP_W-1:0] OP_BR  = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0101);
  localparam logic [OP_W-1:0] OP_LDR = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_STR = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(4'b1001);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_NOT  = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_PASS = ALUOP_W'(2'b11);

  localparam logic [BE_W-1:0] BE_WORD = BE_W'(2'b11);

  typedef enum logic [3:0] {
    FETCH1,
    FETCH2,
    FETCH3,
    DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    BR,
    BR_TAKEN,
    CALC_ADDR,
    LDR1,
    LDR2,
    STR1,
    STR2
  } state_t;

  state_t state;
  state_t next_state;

  // State register; reset always lands in FETCH1, even mid memory wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH1;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; mem_resp only matters in the three memory wait states.
  always_comb begin
    next_state = state;
    case (state)
      FETCH1:    next_state = FETCH2;
      FETCH2:    next_state = mem_resp ? FETCH3 : FETCH2;
      FETCH3:    next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_ADD:         next_state = S_ADD;
          OP_AND:         next_state = S_AND;
          OP_NOT:         next_state = S_NOT;
          OP_BR:          next_state = BR;
          OP_LDR, OP_STR: next_state = CALC_ADDR;
          default:        next_state = FETCH1;
        endcase
      end
      S_ADD:     next_state = FETCH1;
      S_AND:     next_state = FETCH1;
      S_NOT:     next_state = FETCH1;
      BR:        next_state = branch_enable ? BR_TAKEN : FETCH1;
      BR_TAKEN:  next_state = FETCH1;
      CALC_ADDR: next_state = (opcode == OP_LDR) ? LDR1 : STR1;
      LDR1:      next_state = mem_resp ? LDR2 : LDR1;
      LDR2:      next_state = FETCH1;
      STR1:      next_state = STR2;
      STR2:      next_state = mem_resp ? FETCH1 : STR2;
      default:   next_state = FETCH1;
    endcase
  end

  // Output decode of the current state, held at zero while reset is asserted.
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_cc         = 1'b0;
    pcmux_sel       = 1'b0;
    storemux_sel    = 1'b0;
    alumux_sel      = 1'b0;
    regfilemux_sel  = 1'b0;
    marmux_sel      = 1'b0;
    mdrmux_sel      = 1'b0;
    aluop           = ALU_ADD;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = BE_W'(2'b00);
    if (rst_n) begin
      mem_byte_enable = BE_WORD;
      case (state)
        FETCH1: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          load_pc    = 1'b1;
        end
        FETCH2, LDR1: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
        end
        FETCH3: load_ir = 1'b1;
        S_ADD, S_AND, S_NOT: begin
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          aluop        = (state == S_AND) ? ALU_AND :
                         (state == S_NOT) ? ALU_NOT : ALU_ADD;
        end
        BR_TAKEN: begin
          pcmux_sel = 1'b1;
          load_pc   = 1'b1;
        end
        CALC_ADDR: begin
          alumux_sel = 1'b1;
          aluop      = ALU_ADD;
          load_mar   = 1'b1;
        end
        LDR2: begin
          regfilemux_sel = 1'b1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        STR1: begin
          storemux_sel = 1'b1;
          aluop        = ALU_PASS;
          load_mdr     = 1'b1;
        end
        STR2: mem_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Directed bench for the controller: each scenario walks the FSM cycle by
// cycle and compares the full output vector against hand-derived constants.
module tb_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       branch_enable;
  logic       mem_resp;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic       pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel;
  logic [1:0] aluop;
  logic       mem_read, mem_write;
  logic [1:0] mem_byte_enable;

  int checks = 0;
  int errs   = 0;

  control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_enable(branch_enable),
    .mem_resp(mem_resp), .load_pc(load_pc), .load_ir(load_ir),
    .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
    .load_cc(load_cc), .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel),
    .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
    .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel), .aluop(aluop),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable)
  );

  // {loads pc,ir,rf,mar,mdr,cc | sel pc,store,alu,rf,mar,mdr | aluop | rd,wr | be}
  logic [17:0] obs;
  assign obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel,
                mdrmux_sel, aluop, mem_read, mem_write, mem_byte_enable};

  localparam logic [17:0] E_RST  = 18'b000000_000000_00_00_00;
  localparam logic [17:0] E_F1   = 18'b100100_000010_00_00_11;
  localparam logic [17:0] E_RD   = 18'b000010_000001_00_10_11;
  localparam logic [17:0] E_F3   = 18'b010000_000000_00_00_11;
  localparam logic [17:0] E_IDLE = 18'b000000_000000_00_00_11;
  localparam logic [17:0] E_ADD  = 18'b001001_000000_00_00_11;
  localparam logic [17:0] E_AND  = 18'b001001_000000_01_00_11;
  localparam logic [17:0] E_NOT  = 18'b001001_000000_10_00_11;
  localparam logic [17:0] E_BRT  = 18'b100000_100000_00_00_11;
  localparam logic [17:0] E_CALC = 18'b000100_001000_00_00_11;
  localparam logic [17:0] E_LDR2 = 18'b001001_000100_00_00_11;
  localparam logic [17:0] E_STR1 = 18'b000010_010000_11_00_11;
  localparam logic [17:0] E_STR2 = 18'b000000_000000_00_01_11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs FETCH1..DECODE with w wait cycles; returns sitting in DECODE.
  task automatic do_fetch(input logic [3:0] op, input int w);
    checks++; if (obs !== E_F1) begin errs++; $display("FAIL fetch1: got %b want %b", obs, E_F1); end
    mem_resp = 1'b0;
    tick();
    for (int i = 0; i < w; i++) begin
      checks++; if (obs !== E_RD) begin errs++; $display("FAIL fetch2_wait%0d: got %b want %b", i, obs, E_RD); end
      tick();
    end
    checks++; if (obs !== E_RD) begin errs++; $display("FAIL fetch2_resp: got %b want %b", obs, E_RD); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (obs !== E_F3) begin errs++; $display("FAIL fetch3: got %b want %b", obs, E_F3); end
    opcode = op;
    tick();
    checks++; if (obs !== E_IDLE) begin errs++; $display("FAIL decode: got %b want %b", obs, E_IDLE); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_resp = 1'b0; opcode = 4'b0000; branch_enable = 1'b0;
    tick();
    checks++; if (obs !== E_RST) begin errs++; $display("FAIL reset_cycle1: got %b want %b", obs, E_RST); end
    mem_resp = 1'b1;
    tick();
    checks++; if (obs !== E_RST) begin errs++; $display("FAIL reset_cycle2: got %b want %b", obs, E_RST); end
    mem_resp = 1'b0;
    rst_n = 1'b1;
    #1;
    do_fetch(4'b0001, 1);
    tick();
    checks++; if (obs !== E_ADD) begin errs++; $display("FAIL reset_add: got %b want %b", obs, E_ADD); end
    tick();
  endtask

  task automatic test_alu();
    logic [3:0]  ops  [3] = '{4'b0001, 4'b0101, 4'b1001};
    logic [17:0] exps [3] = '{E_ADD, E_AND, E_NOT};
    for (int k = 0; k < 3; k++) begin
      do_fetch(ops[k], 0);
      tick();
      checks++; if (obs !== exps[k]) begin errs++; $display("FAIL alu_op%0d: got %b want %b", k, obs, exps[k]); end
      tick();
      checks++; if (obs !== E_F1) begin errs++; $display("FAIL alu_return%0d: got %b want %b", k, obs, E_F1); end
    end
  endtask

  task automatic test_branch();
    do_fetch(4'b0000, 0);
    tick();
    checks++; if (obs !== E_IDLE) begin errs++; $display("FAIL br_state: got %b want %b", obs, E_IDLE); end
    branch_enable = 1'b1;
    tick();
    branch_enable = 1'b0;
    checks++; if (obs !== E_BRT) begin errs++; $display("FAIL br_taken: got %b want %b", obs, E_BRT); end
    tick();
    checks++; if (obs !== E_F1) begin errs++; $display("FAIL br_taken_return: got %b want %b", obs, E_F1); end
    // enable high during DECODE only: must not be taken
    do_fetch(4'b0000, 0);
    branch_enable = 1'b1;
    tick();
    branch_enable = 1'b0;
    checks++; if (obs !== E_IDLE) begin errs++; $display("FAIL br_nt_state: got %b want %b", obs, E_IDLE); end
    tick();
    checks++; if (obs !== E_F1) begin errs++; $display("FAIL br_not_taken: got %b want %b", obs, E_F1); end
  endtask

  task automatic test_ldr();
    do_fetch(4'b0110, 0);
    tick();
    checks++; if (obs !== E_CALC) begin errs++; $display("FAIL ldr_calc: got %b want %b", obs, E_CALC); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs !== E_RD) begin errs++; $display("FAIL ldr1_cycle%0d: got %b want %b", i, obs, E_RD); end
      if (i == 3) mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    checks++; if (obs !== E_LDR2) begin errs++; $display("FAIL ldr2: got %b want %b", obs, E_LDR2); end
    tick();
    checks++; if (obs !== E_F1) begin errs++; $display("FAIL ldr_return: got %b want %b", obs, E_F1); end
  endtask

  task automatic test_str_reset();
    do_fetch(4'b0111, 0);
    tick();
    checks++; if (obs !== E_CALC) begin errs++; $display("FAIL str_calc: got %b want %b", obs, E_CALC); end
    tick();
    checks++; if (obs !== E_STR1) begin errs++; $display("FAIL str1: got %b want %b", obs, E_STR1); end
    tick();
    checks++; if (obs !== E_STR2) begin errs++; $display("FAIL str2_first: got %b want %b", obs, E_STR2); end
    tick();
    checks++; if (obs !== E_STR2) begin errs++; $display("FAIL str2_hold: got %b want %b", obs, E_STR2); end
    rst_n = 1'b0;
    mem_resp = 1'b1;
    #1;
    checks++; if (obs !== E_RST) begin errs++; $display("FAIL str2_reset_drop: got %b want %b", obs, E_RST); end
    tick();
    mem_resp = 1'b0;
    checks++; if (obs !== E_RST) begin errs++; $display("FAIL str2_reset_held: got %b want %b", obs, E_RST); end
    rst_n = 1'b1;
    #1;
    do_fetch(4'b0111, 1);
    tick();
    tick();
    checks++; if (obs !== E_STR1) begin errs++; $display("FAIL str1_again: got %b want %b", obs, E_STR1); end
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (obs !== E_F1) begin errs++; $display("FAIL str_return: got %b want %b", obs, E_F1); end
  endtask

  task automatic test_illegal_stray();
    logic [3:0] ops [3] = '{4'b1111, 4'b0010, 4'b1000};
    for (int k = 0; k < 3; k++) begin
      do_fetch(ops[k], 0);
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      checks++; if (obs !== E_F1) begin errs++; $display("FAIL illegal_op%0d: got %b want %b", k, obs, E_F1); end
    end
    // stray response in DECODE of an ADD still lands in S_ADD
    do_fetch(4'b0001, 0);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (obs !== E_ADD) begin errs++; $display("FAIL stray_decode: got %b want %b", obs, E_ADD); end
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (obs !== E_RD) begin errs++; $display("FAIL stray_fetch1: got %b want %b", obs, E_RD); end
    tick();
    checks++; if (obs !== E_RD) begin errs++; $display("FAIL stray_no_skip: got %b want %b", obs, E_RD); end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (mem_read && mem_write) begin
        errs++;
        $display("FAIL rd_wr_exclusive: got rd=%b wr=%b want not both", mem_read, mem_write);
      end
    end
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_ldr();
    test_str_reset();
    test_illegal_stray();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
